alu_dispatch: RTL and testbench
===============================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL have parameter IDX_W, default 3, register-index width; register file depth is 2**IDX_W.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, request queue entries (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports req_valid_i input 1 / req_ready_o output 1: request handshake, transfer when both high at an edge.
REQ-006 SHALL have ports req_cmd_i input 8 (ALU command code), req_rs1_i / req_rs2_i / req_rd_i input IDX_W (register indices).
REQ-007 SHALL have ports ld_valid_i input 1, ld_addr_i input IDX_W, ld_data_i input 32: direct register-file preload.
REQ-008 SHALL have ports alu_cmd_o output 8, alu_rs1_data_o output 32, alu_rs2_data_o output 32: drive the ALU.
REQ-009 SHALL have ports alu_rd_data_i input 32, alu_zero_i input 1: combinational ALU result and zero flag.
REQ-010 SHALL have ports wb_valid_o output 1, wb_rd_o output IDX_W, wb_data_o output 32, wb_zero_o output 1: writeback report.
REQ-011 SHALL have ports illegal_o output 1 (one-cycle pulse, dropped command) and busy_o output 1 (FIFO non-empty or state != IDLE).

Function
REQ-012 SHALL hold requests in a FIFO of FIFO_DEPTH entries {cmd, rs1, rs2, rd}; req_ready_o = not full, registered-state derived only.
REQ-013 SHALL implement FSM IDLE, ISSUE, WB; IDLE->ISSUE when FIFO non-empty (pop at that edge); ISSUE->WB always; WB->ISSUE if FIFO non-empty (pop) else IDLE.
REQ-014 SHALL, on pop, register cmd, rd and operands regfile[rs1], regfile[rs2]; alu_* outputs driven from these registers only in ISSUE, else alu_cmd_o = 0 and operands 0.
REQ-015 SHALL capture alu_rd_data_i and alu_zero_i at the ISSUE->WB edge into wb_data_o, wb_zero_o; wb_rd_o = captured rd; wb_valid_o high exactly during WB.
REQ-016 SHALL write wb_data_o into regfile[wb_rd_o] at the edge ending WB.
REQ-017 SHALL forward writeback data to a pop occurring at the WB->ISSUE edge when rs1 or rs2 equals wb_rd_o (read-after-write bypass).
REQ-018 SHALL give latency: request accepted at edge E0 -> ISSUE cycle after E1 -> wb_valid_o high cycle after E2; sustained throughput one command per 2 cycles.
REQ-019 SHALL accept a push and a pop in the same edge; a push into an empty FIFO in IDLE is popped no earlier than the following edge.
REQ-020 SHALL apply ld_valid_i writes at the edge sampled; on same-index collision with a WB write, the WB write wins; ld writes to an index being popped are not bypassed.
REQ-021 SHALL treat FIFO pointers as wrap-around modulo FIFO_DEPTH with a separate count for full/empty.

Reset
REQ-022 SHALL, while rst_ni low, force state IDLE, FIFO empty, all regfile entries and all output registers 0, req_ready_o 0 during reset and 1 from the first edge after release.
REQ-023 SHALL discard in-flight and queued commands on reset assertion mid-operation; no wb_valid_o or illegal_o pulse results.

Configuration
REQ-024 SHALL, with ALU_DISPATCH_ILLEGAL_CHECK_EN defined, pop commands whose code is not in {1,2,3,74,75,76,79,80,85,86,87} without entering ISSUE, pulse illegal_o for one cycle, write nothing, and stay in IDLE/re-evaluate FIFO next cycle.
REQ-025 SHALL, without ALU_DISPATCH_ILLEGAL_CHECK_EN, forward every command code to the ALU unchanged and tie illegal_o to 0.

Verification
REQ-026 SHALL cover: ld r1=5, r2=7; cmd 1 rs1=1 rs2=2 rd=3 -> alu_cmd_o=1 in ISSUE, wb_valid_o 2 cycles after accept, wb_data_o=12, wb_zero_o=0, r3=12.
REQ-027 SHALL cover: back-to-back cmd 1 (r3=r1+r2) then cmd 2 rs1=3 rd=4 -> second ISSUE sees alu_rs1_data_o=12 via bypass, r4=12.
REQ-028 SHALL cover: hold ALU stalled-free, push 5 requests with DEPTH 4 and no pops possible -> req_ready_o low after 4th queued, 5th accepted only after first pop; all 5 write back in order.
REQ-029 SHALL cover: with ALU_DISPATCH_ILLEGAL_CHECK_EN, cmd 200 -> illegal_o one pulse, no wb_valid_o, regfile unchanged; without macro, alu_cmd_o=200 and wb_valid_o pulses.
REQ-030 SHALL cover: rst_ni low during ISSUE with 3 queued -> all outputs 0, busy_o 0 after release, no writeback of discarded commands.
REQ-031 SHALL cover: cmd 1 with r1=0, r2=0 -> wb_zero_o=1; simultaneous ld to wb_rd_o index -> regfile holds WB data.

Source files
------------

// File: rtl/alu_dispatch.sv
// Queues ALU requests, reads operands from a local register file, drives the ALU and writes back.
// Define ALU_DISPATCH_ILLEGAL_CHECK_EN to drop unsupported command codes with an illegal_o pulse.
module alu_dispatch #(
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [7:0]       req_cmd_i,
    input  logic [IDX_W-1:0] req_rs1_i,
    input  logic [IDX_W-1:0] req_rs2_i,
    input  logic [IDX_W-1:0] req_rd_i,
    input  logic             ld_valid_i,
    input  logic [IDX_W-1:0] ld_addr_i,
    input  logic [31:0]      ld_data_i,
    output logic [7:0]       alu_cmd_o,
    output logic [31:0]      alu_rs1_data_o,
    output logic [31:0]      alu_rs2_data_o,
    input  logic [31:0]      alu_rd_data_i,
    input  logic             alu_zero_i,
    output logic             wb_valid_o,
    output logic [IDX_W-1:0] wb_rd_o,
    output logic [31:0]      wb_data_o,
    output logic             wb_zero_o,
    output logic             illegal_o,
    output logic             busy_o
);

    localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned NumRegs = 2 ** IDX_W;

    typedef struct packed {
        logic [7:0]       cmd;
        logic [IDX_W-1:0] rs1;
        logic [IDX_W-1:0] rs2;
        logic [IDX_W-1:0] rd;
    } req_t;

    typedef enum logic [1:0] {StIdle, StIssue, StWb} state_e;

    state_e           state_q, state_d;
    req_t             fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             rdy_q;
    logic [31:0]      rf_q [NumRegs];
    logic [7:0]       cmd_q;
    logic [IDX_W-1:0] rd_q, wb_rd_q;
    logic [31:0]      op1_q, op2_q, wb_data_q;
    logic             wb_zero_q;

    req_t        head;
    logic        fifo_empty, fifo_full, push, pop, head_legal;
    logic [31:0] op1_d, op2_d;

`ifdef ALU_DISPATCH_ILLEGAL_CHECK_EN
    logic illegal_q;

    function automatic logic cmd_legal(input logic [7:0] c);
        case (c)
            8'd1, 8'd2, 8'd3, 8'd74, 8'd75, 8'd76, 8'd79, 8'd80, 8'd85, 8'd86, 8'd87: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign head_legal = cmd_legal(head.cmd);
    assign illegal_o  = illegal_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= pop && !head_legal;
        end
    end
`else
    assign head_legal = 1'b1;
    assign illegal_o  = 1'b0;
`endif

    assign head        = fifo_q[rd_ptr_q];
    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CntW'(FIFO_DEPTH));
    assign req_ready_o = rdy_q && !fifo_full;
    assign push        = req_valid_i && req_ready_o;
    assign pop         = ((state_q == StIdle) || (state_q == StWb)) && !fifo_empty;

    // Read-after-write bypass: the writeback lands in rf_q on the same edge as this pop.
    assign op1_d = ((state_q == StWb) && (head.rs1 == wb_rd_q)) ? wb_data_q : rf_q[head.rs1];
    assign op2_d = ((state_q == StWb) && (head.rs2 == wb_rd_q)) ? wb_data_q : rf_q[head.rs2];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StWb: begin
                if (pop && head_legal) begin
                    state_d = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            StIssue: state_d = StWb;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdy_q   <= 1'b1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Queue storage needs no reset; count_q alone defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{cmd: req_cmd_i, rs1: req_rs1_i, rs2: req_rs2_i, rd: req_rd_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q     <= '0;
            rd_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_zero_q <= 1'b0;
        end else begin
            if (pop && head_legal) begin
                cmd_q <= head.cmd;
                rd_q  <= head.rd;
                op1_q <= op1_d;
                op2_q <= op2_d;
            end
            if (state_q == StIssue) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= alu_rd_data_i;
                wb_zero_q <= alu_zero_i;
            end
        end
    end

    // Writeback is applied after the preload so it wins on an index collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (ld_valid_i) begin
                rf_q[ld_addr_i] <= ld_data_i;
            end
            if (state_q == StWb) begin
                rf_q[wb_rd_q] <= wb_data_q;
            end
        end
    end

    assign alu_cmd_o      = (state_q == StIssue) ? cmd_q : '0;
    assign alu_rs1_data_o = (state_q == StIssue) ? op1_q : '0;
    assign alu_rs2_data_o = (state_q == StIssue) ? op2_q : '0;
    assign wb_valid_o     = (state_q == StWb);
    assign wb_rd_o        = wb_rd_q;
    assign wb_data_o      = wb_data_q;
    assign wb_zero_o      = wb_zero_q;
    assign busy_o         = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a small combinational ALU model (1 add, 2 sub, 3 and,
// anything else xor); expected values are hand-derived from the preloaded register values.
module tb_alu_dispatch;

    localparam int unsigned IDX_W = 3;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [7:0]       req_cmd_i;
    logic [IDX_W-1:0] req_rs1_i, req_rs2_i, req_rd_i;
    logic             ld_valid_i;
    logic [IDX_W-1:0] ld_addr_i;
    logic [31:0]      ld_data_i;
    logic [7:0]       alu_cmd_o;
    logic [31:0]      alu_rs1_data_o, alu_rs2_data_o, alu_rd_data_i;
    logic             alu_zero_i;
    logic             wb_valid_o;
    logic [IDX_W-1:0] wb_rd_o;
    logic [31:0]      wb_data_o;
    logic             wb_zero_o;
    logic             illegal_o;
    logic             busy_o;

    int checks   = 0;
    int failures = 0;

    logic [IDX_W+31:0] wb_log[$];
    logic [IDX_W+31:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    alu_dispatch #(
        .IDX_W     (IDX_W),
        .FIFO_DEPTH(4)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_cmd_i     (req_cmd_i),
        .req_rs1_i     (req_rs1_i),
        .req_rs2_i     (req_rs2_i),
        .req_rd_i      (req_rd_i),
        .ld_valid_i    (ld_valid_i),
        .ld_addr_i     (ld_addr_i),
        .ld_data_i     (ld_data_i),
        .alu_cmd_o     (alu_cmd_o),
        .alu_rs1_data_o(alu_rs1_data_o),
        .alu_rs2_data_o(alu_rs2_data_o),
        .alu_rd_data_i (alu_rd_data_i),
        .alu_zero_i    (alu_zero_i),
        .wb_valid_o    (wb_valid_o),
        .wb_rd_o       (wb_rd_o),
        .wb_data_o     (wb_data_o),
        .wb_zero_o     (wb_zero_o),
        .illegal_o     (illegal_o),
        .busy_o        (busy_o)
    );

    function automatic logic [31:0] alu_model(input logic [7:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        case (c)
            8'd1:    return a + b;
            8'd2:    return a - b;
            8'd3:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb begin
        alu_rd_data_i = alu_model(alu_cmd_o, alu_rs1_data_o, alu_rs2_data_o);
        alu_zero_i    = (alu_rd_data_i == 32'd0);
    end

    always @(negedge clk_i) begin
        if (wb_valid_o) wb_log.push_back({wb_rd_o, wb_data_o});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [7:0] c, input int rs1, input int rs2, input int rd);
        req_cmd_i   = c;
        req_rs1_i   = IDX_W'(rs1);
        req_rs2_i   = IDX_W'(rs2);
        req_rd_i    = IDX_W'(rd);
        req_valid_i = 1'b1;
    endtask

    // Leaves req_valid_i high so consecutive calls push back-to-back.
    task automatic push(input logic [7:0] c, input int rs1, input int rs2, input int rd,
                        output int waits);
        set_req(c, rs1, rs2, rd);
        waits = 0;
        while (!req_ready_o && waits < 50) begin
            step();
            waits++;
        end
        if (waits >= 50) check_eq("push_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        ld_valid_i = 1'b1;
        ld_addr_i  = IDX_W'(addr);
        ld_data_i  = data;
        step();
        ld_valid_i = 1'b0;
    endtask

    task automatic run_one(input logic [7:0] c, input int rs1, input int rs2, input int rd,
                           output logic [31:0] a, output logic [31:0] b, output logic [31:0] d);
        set_req(c, rs1, rs2, rd);
        step();
        req_valid_i = 1'b0;
        step();
        a = alu_rs1_data_o;
        b = alu_rs2_data_o;
        step();
        d = wb_data_o;
        step();
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy_o && n < 100) begin
            step();
            n++;
        end
        check_eq("drain", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int waits;
        logic [31:0] a, b, d;
        logic [7:0]  c;
        int rd;

        rst_ni = 1'b0;
        req_valid_i = 1'b0;
        req_cmd_i = '0; req_rs1_i = '0; req_rs2_i = '0; req_rd_i = '0;
        ld_valid_i = 1'b0; ld_addr_i = '0; ld_data_i = '0;
        #2;
        check_eq("rst_ready", 32'(req_ready_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check_eq("rst_alu_cmd", 32'(alu_cmd_o), 32'd0);
        check_eq("rst_wb_data", wb_data_o, 32'd0);
        step();
        step();
        check_eq("rst_ready_held", 32'(req_ready_o), 32'd0);
        rst_ni = 1'b1;
        step();
        check_eq("ready_after_rst", 32'(req_ready_o), 32'd1);

        // Basic add with exact latency.
        load(1, 32'd5);
        load(2, 32'd7);
        set_req(8'd1, 1, 2, 3);
        step();
        req_valid_i = 1'b0;
        check_eq("t1_busy", 32'(busy_o), 32'd1);
        check_eq("t1_no_issue_yet", 32'(alu_cmd_o), 32'd0);
        step();
        check_eq("t1_alu_cmd", 32'(alu_cmd_o), 32'd1);
        check_eq("t1_rs1", alu_rs1_data_o, 32'd5);
        check_eq("t1_rs2", alu_rs2_data_o, 32'd7);
        check_eq("t1_wb_early", 32'(wb_valid_o), 32'd0);
        step();
        check_eq("t1_wb_valid", 32'(wb_valid_o), 32'd1);
        check_eq("t1_wb_data", wb_data_o, 32'd12);
        check_eq("t1_wb_zero", 32'(wb_zero_o), 32'd0);
        check_eq("t1_wb_rd", 32'(wb_rd_o), 32'd3);
        check_eq("t1_alu_idle", 32'(alu_cmd_o), 32'd0);
        step();
        check_eq("t1_wb_done", 32'(wb_valid_o), 32'd0);
        check_eq("t1_idle", 32'(busy_o), 32'd0);

        // Back-to-back dependency: r3 preloaded stale so only the bypass yields 12.
        load(3, 32'd99);
        set_req(8'd1, 1, 2, 3);
        step();
        set_req(8'd2, 3, 0, 4);
        step();
        req_valid_i = 1'b0;
        check_eq("t2_issue1", 32'(alu_cmd_o), 32'd1);
        step();
        step();
        check_eq("t2_issue2_cmd", 32'(alu_cmd_o), 32'd2);
        check_eq("t2_bypass_rs1", alu_rs1_data_o, 32'd12);
        check_eq("t2_rs2", alu_rs2_data_o, 32'd0);
        step();
        check_eq("t2_wb_data", wb_data_o, 32'd12);
        check_eq("t2_wb_rd", 32'(wb_rd_o), 32'd4);
        step();
        run_one(8'd1, 4, 3, 6, a, b, d);
        check_eq("t2_r4", a, 32'd12);
        check_eq("t2_r3", b, 32'd12);
        check_eq("t2_sum", d, 32'd24);

        // Fill the queue: pops only every other edge, so the 7th push fills it.
        wb_log.delete();
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            c  = 8'((k % 3) + 1);
            rd = 5 + (k % 3);
            push(c, 1, 2, rd, waits);
            exp_q.push_back({IDX_W'(rd), alu_model(c, 32'd5, 32'd7)});
            if (k == 6) check_eq("t3_full_ready", 32'(req_ready_o), 32'd0);
            if (k == 7) check_eq("t3_full_wait", 32'(waits), 32'd1);
        end
        req_valid_i = 1'b0;
        wait_idle();
        check_eq("t3_wb_count", 32'(wb_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < wb_log.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("t3_wb_data%0d", i), wb_log[i][31:0], exp_q[i][31:0]);
            check_eq($sformatf("t3_wb_rd%0d", i), 32'(wb_log[i][IDX_W+31:32]),
                     32'(exp_q[i][IDX_W+31:32]));
        end

        // Unsupported command code 200.
        wb_log.delete();
`ifdef ALU_DISPATCH_ILLEGAL_CHECK_EN
        set_req(8'd200, 1, 2, 6);
        step();
        req_valid_i = 1'b0;
        check_eq("t4_illegal_pre", 32'(illegal_o), 32'd0);
        step();
        check_eq("t4_illegal", 32'(illegal_o), 32'd1);
        check_eq("t4_no_issue", 32'(alu_cmd_o), 32'd0);
        step();
        check_eq("t4_illegal_end", 32'(illegal_o), 32'd0);
        check_eq("t4_idle", 32'(busy_o), 32'd0);
        check_eq("t4_no_wb", 32'(wb_log.size()), 32'd0);
        run_one(8'd1, 6, 0, 7, a, b, d);
        check_eq("t4_r6_kept", a, 32'hFFFF_FFFE);
`else
        set_req(8'd200, 1, 2, 6);
        step();
        req_valid_i = 1'b0;
        step();
        check_eq("t4_alu_cmd", 32'(alu_cmd_o), 32'd200);
        check_eq("t4_illegal", 32'(illegal_o), 32'd0);
        step();
        check_eq("t4_wb_valid", 32'(wb_valid_o), 32'd1);
        check_eq("t4_wb_data", wb_data_o, 32'd2);
        check_eq("t4_wb_rd", 32'(wb_rd_o), 32'd6);
        step();
`endif

        // Reset mid-ISSUE with three requests still queued.
        for (int k = 0; k < 6; k++) push(8'd1, 1, 2, 5, waits);
        req_valid_i = 1'b0;
        check_eq("t5_in_issue", 32'(alu_cmd_o), 32'd1);
        check_eq("t5_busy", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        wb_log.delete();
        check_eq("t5_rst_ready", 32'(req_ready_o), 32'd0);
        check_eq("t5_rst_busy", 32'(busy_o), 32'd0);
        check_eq("t5_rst_alu_cmd", 32'(alu_cmd_o), 32'd0);
        check_eq("t5_rst_alu_rs1", alu_rs1_data_o, 32'd0);
        check_eq("t5_rst_wb_data", wb_data_o, 32'd0);
        check_eq("t5_rst_wb_rd", 32'(wb_rd_o), 32'd0);
        check_eq("t5_rst_illegal", 32'(illegal_o), 32'd0);
        step();
        rst_ni = 1'b1;
        step();
        check_eq("t5_ready_after", 32'(req_ready_o), 32'd1);
        check_eq("t5_busy_after", 32'(busy_o), 32'd0);
        repeat (8) step();
        check_eq("t5_no_wb", 32'(wb_log.size()), 32'd0);

        // Zero flag from an all-zero register file, then WB beats a same-index preload.
        set_req(8'd1, 1, 2, 3);
        step();
        req_valid_i = 1'b0;
        step();
        step();
        check_eq("t6_wb_valid", 32'(wb_valid_o), 32'd1);
        check_eq("t6_wb_zero", 32'(wb_zero_o), 32'd1);
        check_eq("t6_wb_data", wb_data_o, 32'd0);
        step();
        load(1, 32'd9);
        set_req(8'd1, 1, 0, 3);
        step();
        req_valid_i = 1'b0;
        step();
        step();
        check_eq("t6_wb9", wb_data_o, 32'd9);
        check_eq("t6_wb9_zero", 32'(wb_zero_o), 32'd0);
        ld_valid_i = 1'b1;
        ld_addr_i  = IDX_W'(3);
        ld_data_i  = 32'hAA;
        step();
        ld_valid_i = 1'b0;
        run_one(8'd1, 3, 0, 4, a, b, d);
        check_eq("t6_wb_wins", a, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
